// File: rtl/vip_sobel_pkg.sv
// Shared types, pipeline constants and default frame geometry for the Sobel edge detector slice.
package vip_sobel_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [10:0] mag_t;
  typedef logic [9:0]  absg_t;

  localparam int SOBEL_LATENCY  = 5;
  localparam int MATRIX_LATENCY = 2;

  localparam int IMG_HDISP_DEF = 640;
  localparam int IMG_VDISP_DEF = 480;

  function automatic absg_t abs_diff(input absg_t a, input absg_t b);
    return (a >= b) ? absg_t'(a - b) : absg_t'(b - a);
  endfunction

endpackage

// File: rtl/vip_matrix_generate_3x3_8bit.sv
// 3x3 pixel window built from two line buffers; window and sync outputs trail the input by two clocks.
module vip_matrix_generate_3x3_8bit
  import vip_sobel_pkg::*;
#(
  parameter int IMG_HDISP = IMG_HDISP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  output logic       matrix_frame_vsync,
  output logic       matrix_frame_href,
  output logic       matrix_frame_clken,
  output pixel_t     matrix_p11,
  output pixel_t     matrix_p12,
  output pixel_t     matrix_p13,
  output pixel_t     matrix_p21,
  output pixel_t     matrix_p22,
  output pixel_t     matrix_p23,
  output pixel_t     matrix_p31,
  output pixel_t     matrix_p32,
  output pixel_t     matrix_p33
);

  localparam int AW = $clog2(IMG_HDISP);
  localparam int CW = $clog2(IMG_HDISP + 1);

  pixel_t lb_top [IMG_HDISP];
  pixel_t lb_mid [IMG_HDISP];

  logic [CW-1:0] col;
  logic [AW-1:0] addr;
  logic          in_range;
  logic          wr_en;
  pixel_t        row_top, row_mid, row_bot;
  logic [1:0]    vs_d, hs_d, ck_d;

  assign addr     = col[AW-1:0];
  assign in_range = (col < CW'(IMG_HDISP));
  assign wr_en    = per_frame_clken & per_frame_href & in_range;

  // Each write pushes the middle line down into the top line at the same column (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb_mid[addr] <= per_img_Y;
      lb_top[addr] <= lb_mid[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row_top <= '0;
      row_mid <= '0;
      row_bot <= '0;
      vs_d    <= '0;
      hs_d    <= '0;
      ck_d    <= '0;
    end else begin
      vs_d <= {vs_d[0], per_frame_vsync};
      hs_d <= {hs_d[0], per_frame_href};
      ck_d <= {ck_d[0], per_frame_clken};
      if (!per_frame_href)
        col <= '0;
      else if (per_frame_clken && in_range)
        col <= col + 1'b1;
      if (per_frame_clken) begin
        row_top <= in_range ? lb_top[addr] : '0;
        row_mid <= in_range ? lb_mid[addr] : '0;
        row_bot <= per_img_Y;
      end
    end
  end

  // Window shifts left one column per accepted pixel, newest column entering at P13/P23/P33.
  always_ff @(posedge clk) begin
    if (rst) begin
      matrix_p11 <= '0; matrix_p12 <= '0; matrix_p13 <= '0;
      matrix_p21 <= '0; matrix_p22 <= '0; matrix_p23 <= '0;
      matrix_p31 <= '0; matrix_p32 <= '0; matrix_p33 <= '0;
    end else if (ck_d[0]) begin
      matrix_p11 <= matrix_p12; matrix_p12 <= matrix_p13; matrix_p13 <= row_top;
      matrix_p21 <= matrix_p22; matrix_p22 <= matrix_p23; matrix_p23 <= row_mid;
      matrix_p31 <= matrix_p32; matrix_p32 <= matrix_p33; matrix_p33 <= row_bot;
    end
  end

  assign matrix_frame_vsync = vs_d[1];
  assign matrix_frame_href  = hs_d[1];
  assign matrix_frame_clken = ck_d[1];

endmodule

// File: rtl/vip_gray_sobel_edge_detector.sv
// Sobel edge detector: 3x3 window -> |Gx|+|Gy| -> strict threshold -> binary edge image, 5 clk latency.
// Build option SOBEL_GRAY_OUT_EN: post_img_Y carries the saturated magnitude instead of the replicated edge bit.
module vip_gray_sobel_edge_detector
  import vip_sobel_pkg::*;
#(
  parameter int IMG_HDISP = IMG_HDISP_DEF,
  parameter int IMG_VDISP = IMG_VDISP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_Y,
  input  logic [7:0] Sobel_Threshold,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic       post_img_Bit,
  output logic [7:0] post_img_Y
);

  localparam int CW   = $clog2(IMG_HDISP + 1);
  localparam int RW   = $clog2(IMG_VDISP + 1);
  localparam int TAIL = SOBEL_LATENCY - MATRIX_LATENCY;

  logic   matrix_vsync, matrix_href, matrix_clken;
  pixel_t p11, p12, p13, p21, p23, p31, p32, p33;
  // Centre pixel carries zero weight in both kernels.
  pixel_t centre_unused;

  vip_matrix_generate_3x3_8bit #(.IMG_HDISP(IMG_HDISP)) u_matrix (
    .clk                (clk),
    .rst                (rst),
    .per_frame_vsync    (per_frame_vsync),
    .per_frame_href     (per_frame_href),
    .per_frame_clken    (per_frame_clken),
    .per_img_Y          (per_img_Y),
    .matrix_frame_vsync (matrix_vsync),
    .matrix_frame_href  (matrix_href),
    .matrix_frame_clken (matrix_clken),
    .matrix_p11         (p11),
    .matrix_p12         (p12),
    .matrix_p13         (p13),
    .matrix_p21         (p21),
    .matrix_p22         (centre_unused),
    .matrix_p23         (p23),
    .matrix_p31         (p31),
    .matrix_p32         (p32),
    .matrix_p33         (p33)
  );

  logic          vsync_d, href_d, vsync_rise, href_fall;
  logic          frame_active, win_ok;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  pixel_t        thr_reg;

  assign vsync_rise = per_frame_vsync & ~vsync_d;
  assign href_fall  = href_d & ~per_frame_href;

  // Window is only complete once two lines and two columns of the current frame have been seen.
  assign win_ok = per_frame_clken & per_frame_href & frame_active
                & (row_cnt >= RW'(2)) & (row_cnt < RW'(IMG_VDISP))
                & (col_cnt >= CW'(2)) & (col_cnt < CW'(IMG_HDISP));

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_d      <= 1'b0;
      href_d       <= 1'b0;
      frame_active <= 1'b0;
      thr_reg      <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
      if (vsync_rise) begin
        thr_reg      <= Sobel_Threshold;
        frame_active <= 1'b1;
      end
      if (!per_frame_href)
        col_cnt <= '0;
      else if (per_frame_clken && col_cnt < CW'(IMG_HDISP))
        col_cnt <= col_cnt + 1'b1;
      if (vsync_rise)
        row_cnt <= '0;
      else if (href_fall && row_cnt < RW'(IMG_VDISP))
        row_cnt <= row_cnt + 1'b1;
    end
  end

  absg_t                  sx1, sx3, sy1, sy3;
  mag_t                   mag_reg, mag_m;
  logic                   bit_next;
  logic [SOBEL_LATENCY-2:0] ok_sr;
  logic [TAIL-1:0]        vs_sr, hs_sr, ck_sr;

  assign mag_m    = ok_sr[SOBEL_LATENCY-2] ? mag_reg : '0;
  assign bit_next = (mag_m > mag_t'(thr_reg));

  // Column sums, then abs-diff and add, then compare; the window-valid flag rides alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx1          <= '0;
      sx3          <= '0;
      sy1          <= '0;
      sy3          <= '0;
      mag_reg      <= '0;
      ok_sr        <= '0;
      vs_sr        <= '0;
      hs_sr        <= '0;
      ck_sr        <= '0;
      post_img_Bit <= 1'b0;
      post_img_Y   <= '0;
    end else begin
      sx1     <= absg_t'(p11) + absg_t'({p21, 1'b0}) + absg_t'(p31);
      sx3     <= absg_t'(p13) + absg_t'({p23, 1'b0}) + absg_t'(p33);
      sy1     <= absg_t'(p11) + absg_t'({p12, 1'b0}) + absg_t'(p13);
      sy3     <= absg_t'(p31) + absg_t'({p32, 1'b0}) + absg_t'(p33);
      mag_reg <= mag_t'(abs_diff(sx3, sx1)) + mag_t'(abs_diff(sy3, sy1));
      ok_sr   <= {ok_sr[SOBEL_LATENCY-3:0], win_ok};
      vs_sr   <= {vs_sr[TAIL-2:0], matrix_vsync};
      hs_sr   <= {hs_sr[TAIL-2:0], matrix_href};
      ck_sr   <= {ck_sr[TAIL-2:0], matrix_clken};
      post_img_Bit <= bit_next;
`ifdef SOBEL_GRAY_OUT_EN
      post_img_Y   <= (mag_m > mag_t'(255)) ? 8'd255 : mag_m[7:0];
`else
      post_img_Y   <= {8{bit_next}};
`endif
    end
  end

  assign post_frame_vsync = vs_sr[TAIL-1];
  assign post_frame_href  = hs_sr[TAIL-1];
  assign post_frame_clken = ck_sr[TAIL-1];

endmodule

// File: tb/tb_vip_gray_sobel_edge_detector.sv
// Directed bench for the Sobel edge detector on a 16x8 frame: step, ramp and threshold patterns plus mid-line reset.
module tb_vip_gray_sobel_edge_detector;

  localparam int H = 16;
  localparam int V = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       per_frame_vsync = 1'b0;
  logic       per_frame_href = 1'b0;
  logic       per_frame_clken = 1'b0;
  logic [7:0] per_img_Y = 8'd0;
  logic [7:0] Sobel_Threshold = 8'd0;
  logic       post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;
  logic [7:0] post_img_Y;

  always #5 clk = ~clk;

  vip_gray_sobel_edge_detector #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk              (clk),
    .rst              (rst),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_Y        (per_img_Y),
    .Sobel_Threshold  (Sobel_Threshold),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_Bit     (post_img_Bit),
    .post_img_Y       (post_img_Y)
  );

  typedef struct {
    logic       b;
    logic [7:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cur_mode = 0;
  int   cur_lo = 0;
  int   cur_hi = 0;
  int   thr_model = 0;
  bit   frame_active_m = 1'b0;
  bit   suppress = 1'b0;
  bit   flush_pending = 1'b0;
  int   skip = 0;
  bit   rst_prev = 1'b0;
  logic [2:0] hist [5];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
  endtask

  // Modes: 0 vertical step at col 8, 1 horizontal step at row 4, 2 descending ramp in both axes.
  function automatic int pix(input int r, input int c);
    case (cur_mode)
      0:       return (c < 8) ? cur_lo : cur_hi;
      1:       return (r < 4) ? cur_lo : cur_hi;
      default: return 200 - 10 * c - 7 * r;
    endcase
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int calc_mag(input int r, input int c);
    int p [3][3];
    int sx1, sx3, sy1, sy3;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = pix(r - 2 + i, c - 2 + j);
    sx1 = p[0][0] + 2 * p[1][0] + p[2][0];
    sx3 = p[0][2] + 2 * p[1][2] + p[2][2];
    sy1 = p[0][0] + 2 * p[0][1] + p[0][2];
    sy3 = p[2][0] + 2 * p[2][1] + p[2][2];
    return iabs(sx3 - sx1) + iabs(sy3 - sy1);
  endfunction

  function automatic exp_t model(input int r, input int c);
    exp_t e;
    int   m;
    m = (frame_active_m && !suppress && r >= 2 && c >= 2) ? calc_mag(r, c) : 0;
    e.b = (m > thr_model);
`ifdef SOBEL_GRAY_OUT_EN
    e.y = (m > 255) ? 8'd255 : 8'(m);
`else
    e.y = {8{e.b}};
`endif
    return e;
  endfunction

  task automatic applyStimulus(input logic r_, input logic v, input logic h, input logic ce, input logic [7:0] y);
    @(posedge clk);
    #1;
    if (flush_pending) begin
      exp_q.delete();
      flush_pending = 1'b0;
    end
    rst             = r_;
    per_frame_vsync = v;
    per_frame_href  = h;
    per_frame_clken = ce;
    per_img_Y       = y;
  endtask

  task automatic sendFrame(input int mode, input int lo, input int hi,
                           input int thr_row, input int rst_row, input int rst_col);
    cur_mode = mode;
    cur_lo   = lo;
    cur_hi   = hi;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      if (i == 0) begin
        thr_model      = int'(Sobel_Threshold);
        frame_active_m = 1'b1;
        suppress       = 1'b0;
      end
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int r = 0; r < V; r++) begin
      if (r == thr_row) Sobel_Threshold = 8'd255;
      for (int c = 0; c < H; c++) begin
        if (r == rst_row && c == rst_col) begin
          applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'(pix(r, c)));
          suppress       = 1'b1;
          frame_active_m = 1'b0;
          flush_pending  = 1'b1;
        end else begin
          applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'(pix(r, c)));
          exp_q.push_back(model(r, c));
        end
      end
      repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  // Output monitor: reset clearing, 5-clk sync alignment and per-pixel scoreboard.
  initial begin : monitor
    exp_t e;
    for (int i = 0; i < 5; i++) hist[i] = 3'b000;
    forever begin
      @(negedge clk);
      if (rst_prev)
        checkOutput("reset_outputs_zero",
                    32'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, post_img_Y}), 32'd0);
      if (rst) skip = 6;
      if (skip > 0) skip--;
      else checkOutput("sync_delay5", 32'({post_frame_vsync, post_frame_href, post_frame_clken}), 32'(hist[4]));
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {per_frame_vsync, per_frame_href, per_frame_clken};
      if (post_frame_clken) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("edge_bit", 32'(post_img_Bit), 32'(e.b));
          checkOutput("pixel_y", 32'(post_img_Y), 32'(e.y));
        end
      end
      rst_prev = rst;
    end
  end

  initial begin
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    Sobel_Threshold = 8'd20;
    sendFrame(0, 128, 128, -1, -1, -1);
    Sobel_Threshold = 8'd64;
    sendFrame(0, 0, 255, -1, -1, -1);
    sendFrame(0, 0, 255, 3, -1, -1);
    sendFrame(0, 0, 255, -1, -1, -1);
    sendFrame(0, 0, 64, -1, -1, -1);
    sendFrame(0, 0, 63, -1, -1, -1);
    Sobel_Threshold = 8'd64;
    sendFrame(0, 0, 255, -1, 4, 5);
    sendFrame(0, 0, 255, -1, -1, -1);
    sendFrame(1, 0, 255, -1, -1, -1);
    Sobel_Threshold = 8'd100;
    sendFrame(2, 0, 0, -1, -1, -1);
    Sobel_Threshold = 8'd136;
    sendFrame(2, 0, 0, -1, -1, -1);
    Sobel_Threshold = 8'd64;
    sendFrame(0, 0, 40, -1, -1, -1);

    checkOutput("pending_pixels", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
